// File: rtl/ether_tx.sv
// ether_tx: prepends the 14-byte Ethernet header to a 512-bit payload stream,
// realigning payload bytes across beats by 14 bytes.
module ether_tx (
  input  logic         clk,
  input  logic         reset,
  input  logic [111:0] ether_header_data,
  input  logic         ether_header_valid,
  output logic         ether_header_ready,
  input  logic [511:0] ether_data_data,
  input  logic         ether_data_valid,
  input  logic         ether_data_sop,
  input  logic         ether_data_eop,
  input  logic [7:0]   ether_data_mty,
  output logic         ether_data_ready,
  output logic [511:0] send_data,
  output logic         send_valid,
  output logic         send_sop,
  output logic         send_eop,
  output logic [7:0]   send_mty,
  input  logic         send_ready
);
  typedef enum logic [1:0] {IDLE, BODY, LAST_ONE} state_t;
  state_t       state;
  logic [111:0] carry;
  logic [7:0]   mty_l;
  logic         load_ok, accept, tail_fits;
  always_comb begin
    load_ok = !send_valid || send_ready;
    ether_data_ready = state == IDLE ? load_ok && (!ether_data_sop || ether_header_valid) :
                       state == BODY ? load_ok : 1'b0;
    accept = ether_data_valid && ether_data_ready;
    ether_header_ready = state == IDLE && accept && ether_data_sop;
    tail_fits = ether_data_eop && ether_data_mty >= 8'd14;
  end
  // The 14 shifted-out bytes fit in the last beat's empty tail only when mty >= 14.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      carry      <= '0;
      mty_l      <= '0;
      send_data  <= '0;
      send_valid <= 1'b0;
      send_sop   <= 1'b0;
      send_eop   <= 1'b0;
      send_mty   <= '0;
    end else if (load_ok) begin
      send_valid <= 1'b0;
      if (state == LAST_ONE) begin
        send_data  <= {carry, 400'd0};
        send_valid <= 1'b1;
        send_sop   <= 1'b0;
        send_eop   <= 1'b1;
        send_mty   <= mty_l;
        state      <= IDLE;
      end else if (accept && (state == BODY || ether_data_sop)) begin
        send_data  <= state == IDLE ?
                      {ether_header_data[63:16], ether_header_data[111:64], ether_header_data[15:0], ether_data_data[511:112]} :
                      {carry, ether_data_data[511:112]};
        send_valid <= 1'b1;
        send_sop   <= state == IDLE;
        send_eop   <= tail_fits;
        send_mty   <= tail_fits ? ether_data_mty - 8'd14 : 8'd0;
        carry      <= ether_data_data[111:0];
        mty_l      <= ether_data_mty + 8'd50;
        state      <= tail_fits ? IDLE : ether_data_eop ? LAST_ONE : BODY;
      end
    end
  end
endmodule

// File: tb/tb_ether_tx.sv
// tb_ether_tx: directed frames against a byte-level framing model via an output scoreboard.
module tb_ether_tx;
  logic         clk = 0, reset = 1;
  logic [111:0] ether_header_data = '0;
  logic         ether_header_valid = 0, ether_header_ready;
  logic [511:0] ether_data_data = '0;
  logic         ether_data_valid = 0, ether_data_sop = 0, ether_data_eop = 0, ether_data_ready;
  logic [7:0]   ether_data_mty = '0;
  logic [511:0] send_data;
  logic         send_valid, send_sop, send_eop, send_ready = 1;
  logic [7:0]   send_mty;

  ether_tx dut (
    .clk(clk), .reset(reset),
    .ether_header_data(ether_header_data), .ether_header_valid(ether_header_valid),
    .ether_header_ready(ether_header_ready),
    .ether_data_data(ether_data_data), .ether_data_valid(ether_data_valid),
    .ether_data_sop(ether_data_sop), .ether_data_eop(ether_data_eop),
    .ether_data_mty(ether_data_mty), .ether_data_ready(ether_data_ready),
    .send_data(send_data), .send_valid(send_valid), .send_sop(send_sop),
    .send_eop(send_eop), .send_mty(send_mty), .send_ready(send_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [511:0] d;
    logic         sop, eop;
    logic [7:0]   mty;
  } beat_t;
  typedef logic [7:0] byte_q[$];

  beat_t sb[$];
  int passed = 0, total = 0, hdr_cnt = 0;

  task automatic chk(input string tag, input logic [527:0] obs, input logic [527:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Frame = dst, src, type, payload bytes, packed MSB-first into 64-byte beats.
  task automatic expect_frame(input logic [111:0] h, input byte_q pl, input bit first_only);
    byte_q fr;
    logic [111:0] hb;
    int nb;
    beat_t e;
    hb = {h[63:16], h[111:64], h[15:0]};
    for (int k = 0; k < 14; k++) fr.push_back(hb[111-8*k -: 8]);
    foreach (pl[i]) fr.push_back(pl[i]);
    nb = (fr.size() + 63) / 64;
    for (int b = 0; b < nb; b++) begin
      e.d = '0;
      for (int k = 0; k < 64; k++)
        if (64*b + k < fr.size()) e.d[511-8*k -: 8] = fr[64*b + k];
      e.sop = b == 0;
      e.eop = b == nb - 1;
      e.mty = e.eop ? 8'(nb*64 - fr.size()) : 8'd0;
      sb.push_back(e);
      if (first_only) break;
    end
  endtask

  task automatic send_pkt(input logic [111:0] h, input int len, input int hdr_delay,
                          input bit first_only, output int waits);
    byte_q pl;
    int nin, nsend, t;
    logic acc;
    waits = 0;
    for (int i = 0; i < len; i++) pl.push_back(8'($urandom));
    expect_frame(h, pl, first_only);
    nin = (len + 63) / 64;
    nsend = first_only ? 1 : nin;
    for (int b = 0; b < nsend; b++) begin
      ether_data_data = '0;
      for (int k = 0; k < 64; k++)
        if (64*b + k < len) ether_data_data[511-8*k -: 8] = pl[64*b + k];
      ether_data_sop = b == 0;
      ether_data_eop = b == nin - 1;
      ether_data_mty = ether_data_eop ? 8'(nin*64 - len) : 8'd0;
      ether_header_data = h;
      ether_data_valid = 1;
      ether_header_valid = 0;
      for (int d = 0; d < hdr_delay && b == 0; d++) begin
        @(negedge clk);
        chk("sop without header: ready", ether_data_ready, 0);
        chk("sop without header: no output", send_valid, 0);
        @(posedge clk); #1;
      end
      ether_header_valid = b == 0;
      acc = 0;
      t = 0;
      while (!acc && t < 100) begin
        @(negedge clk);
        acc = ether_data_ready;
        if (!acc) waits++;
        t++;
        @(posedge clk); #1;
      end
      if (!acc) chk("accept timeout", acc, 1);
    end
    ether_data_valid = 0;
    ether_data_sop = 0;
    ether_data_eop = 0;
    ether_header_valid = 0;
  endtask

  logic [527:0] prev;
  logic         stalled = 0;
  always @(negedge clk) begin
    beat_t e;
    if (ether_header_ready) hdr_cnt++;
    if (stalled) chk("hold while stalled", {send_data, send_valid, send_sop, send_eop, send_mty}, prev);
    stalled = send_valid && !send_ready;
    prev = {send_data, send_valid, send_sop, send_eop, send_mty};
    if (send_valid && send_ready) begin
      chk("beat expected", sb.size() != 0, 1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("beat", {send_data, send_sop, send_eop, send_mty}, {e.d, e.sop, e.eop, e.mty});
      end
    end
  end

  initial begin
    int w, hc, t;
    logic [111:0] h1;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("reset outputs", {send_data, send_valid, send_sop, send_eop, send_mty}, 0);
    @(posedge clk); #1;
    reset = 0;
    // single beat, mty 20
    h1 = 112'h0A0B0C0D0E0F_112233445566_6000;
    hc = hdr_cnt;
    send_pkt(h1, 44, 0, 0, w);
    @(negedge clk);
    chk("t1 header", send_data[511:400], 112'h112233445566_0A0B0C0D0E0F_6000);
    chk("t1 mty", send_mty, 6);
    chk("t1 valid/sop/eop", {send_valid, send_sop, send_eop}, 3'b111);
    chk("t1 header_ready pulses", hdr_cnt - hc, 1);
    @(posedge clk); #1;
    // mty 4 -> LAST_ONE bubble, then back-to-back sop
    send_pkt(112'h1, 60, 0, 0, w);
    send_pkt(112'hABCDEF, 44, 0, 0, w);
    chk("bubble after mty<14", w, 1);
    // three beats, last mty 30, then boundaries mty 14 / 13 / 63
    send_pkt({$urandom, $urandom, $urandom, 16'h0800}, 162, 0, 0, w);
    chk("three beat no bubble", w, 0);
    send_pkt({$urandom, $urandom, $urandom, 16'h86DD}, 50, 0, 0, w);
    chk("mty 14 no bubble", w, 0);
    send_pkt({$urandom, $urandom, $urandom, 16'h0806}, 51, 0, 0, w);
    send_pkt({$urandom, $urandom, $urandom, 16'h88B5}, 1, 0, 0, w);
    chk("after mty 13 bubble", w, 1);
    // downstream stall mid-packet
    fork
      send_pkt({$urandom, $urandom, $urandom, 16'h1234}, 250, 0, 0, w);
      begin
        repeat (2) @(posedge clk);
        #1;
        send_ready = 0;
        repeat (5) begin
          @(negedge clk);
          chk("stall ready low", ether_data_ready, 0);
          @(posedge clk); #1;
        end
        send_ready = 1;
      end
    join
    repeat (10) @(posedge clk);
    #1;
    // sop held without header for 3 cycles
    send_pkt({$urandom, $urandom, $urandom, 16'h5555}, 30, 3, 0, w);
    repeat (3) @(posedge clk);
    #1;
    // stray non-sop beat in IDLE
    ether_data_valid = 1;
    ether_data_data = {16{$urandom}};
    @(negedge clk);
    chk("stray accepted", ether_data_ready, 1);
    @(posedge clk); #1;
    ether_data_valid = 0;
    @(negedge clk);
    chk("stray discarded", send_valid, 0);
    @(posedge clk); #1;
    // reset inside BODY
    send_pkt({$urandom, $urandom, $urandom, 16'h7777}, 200, 0, 1, w);
    reset = 1;
    @(posedge clk); #1;
    reset = 0;
    @(negedge clk);
    chk("mid-packet reset outputs", {send_data, send_valid, send_sop, send_eop, send_mty}, 0);
    chk("mid-packet reset idle ready", ether_data_ready, 1);
    @(posedge clk); #1;
    send_pkt({$urandom, $urandom, $urandom, 16'h9999}, 100, 0, 0, w);
    t = 0;
    while (sb.size() != 0 && t < 50) begin
      @(posedge clk);
      t++;
    end
    #1;
    chk("scoreboard drained", sb.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
